// File: rtl/rob_ctrl.sv
// rob_ctrl: 8-entry reorder-buffer controller with RS credit gating,
// CDB result capture and strictly in-order single-entry retire.
module rob_ctrl #(
  parameter int DEPTH  = 8,
  parameter int RS_ADD = 2,
  parameter int RS_MUL = 2
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        alloc_req,
  input  logic [3:0]  alloc_func,
  input  logic [3:0]  alloc_rd,
  output logic        alloc_gnt,
  output logic [2:0]  alloc_idx,
  input  logic        add_rel,
  input  logic        mul_rel,
  input  logic        cdb_valid,
  input  logic [2:0]  cdb_idx,
  input  logic [15:0] cdb_data,
  output logic        commit_valid,
  output logic [2:0]  commit_idx,
  output logic [3:0]  commit_rd,
  output logic [15:0] commit_data,
  output logic        full,
  output logic        empty,
  output logic [3:0]  count,
  output logic        illegal_func
);

  localparam int AW = $clog2(RS_ADD + 1);
  localparam int MW = $clog2(RS_MUL + 1);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] r_ready;
  logic [3:0]       r_rd   [DEPTH];
  logic [15:0]      r_data [DEPTH];
  logic [2:0]       r_head;
  logic [2:0]       r_tail;
  logic [3:0]       r_count;
  logic [AW-1:0]    r_add_cnt;
  logic [MW-1:0]    r_mul_cnt;

  logic          w_add;
  logic          w_mul;
  logic          w_ok;
  logic          w_commit;
  logic          w_cdb_hit;
  logic          w_gnt_add;
  logic          w_gnt_mul;
  logic [3:0]    w_cnt_nxt;
  logic [AW-1:0] w_add_nxt;
  logic [MW-1:0] w_mul_nxt;

  assign w_add = (alloc_func == 4'b0000) |
                 (alloc_func == 4'b0001);
  assign w_mul = (alloc_func == 4'b0010) |
                 (alloc_func == 4'b0011);

  assign w_ok = (w_add & (r_add_cnt < AW'(RS_ADD))) |
                (w_mul & (r_mul_cnt < MW'(RS_MUL)));

  assign alloc_gnt    = alloc_req & ~flush & ~full & w_ok;
  assign alloc_idx    = r_tail;
  assign illegal_func = alloc_req & ~(w_add | w_mul);
  assign count        = r_count;

  assign w_gnt_add = alloc_gnt & w_add;
  assign w_gnt_mul = alloc_gnt & w_mul;

  assign w_commit  = r_busy[r_head] & r_ready[r_head];
  assign w_cdb_hit = cdb_valid & r_busy[cdb_idx] &
                     ~r_ready[cdb_idx];

  // grant+release of one class cancel; lone release saturates at 0
  always_comb begin
    w_add_nxt = r_add_cnt;
    w_mul_nxt = r_mul_cnt;
    w_cnt_nxt = r_count;
    if (w_gnt_add & ~add_rel)
      w_add_nxt = r_add_cnt + 1'b1;
    else if (~w_gnt_add & add_rel & (r_add_cnt != '0))
      w_add_nxt = r_add_cnt - 1'b1;
    if (w_gnt_mul & ~mul_rel)
      w_mul_nxt = r_mul_cnt + 1'b1;
    else if (~w_gnt_mul & mul_rel & (r_mul_cnt != '0))
      w_mul_nxt = r_mul_cnt - 1'b1;
    if (alloc_gnt & ~w_commit)
      w_cnt_nxt = r_count + 1'b1;
    else if (~alloc_gnt & w_commit)
      w_cnt_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= '0;
      r_ready      <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_add_cnt    <= '0;
      r_mul_cnt    <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      commit_valid <= 1'b0;
      commit_idx   <= '0;
      commit_rd    <= '0;
      commit_data  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else if (flush) begin
      r_busy       <= '0;
      r_ready      <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_add_cnt    <= '0;
      r_mul_cnt    <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      commit_valid <= 1'b0;
    end else begin
      commit_valid <= w_commit;
      if (w_commit) begin
        commit_idx      <= r_head;
        commit_rd       <= r_rd[r_head];
        commit_data     <= r_data[r_head];
        r_busy[r_head]  <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_cdb_hit) begin
        r_ready[cdb_idx] <= 1'b1;
        r_data[cdb_idx]  <= cdb_data;
      end
      if (alloc_gnt) begin
        r_busy[r_tail]  <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_rd[r_tail]    <= alloc_rd;
        r_tail          <= r_tail + 1'b1;
      end
      r_count   <= w_cnt_nxt;
      r_add_cnt <= w_add_nxt;
      r_mul_cnt <= w_mul_nxt;
      full      <= (w_cnt_nxt == 4'(DEPTH));
      empty     <= (w_cnt_nxt == 4'd0);
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: queue-based program-order model of the ROB with a
// commit scoreboard drained by an independent monitor.
module tb_rob_ctrl;

  localparam int RS = 2;

  logic        clk1;
  logic        rst_n;
  logic        flush;
  logic        alloc_req;
  logic [3:0]  alloc_func;
  logic [3:0]  alloc_rd;
  logic        alloc_gnt;
  logic [2:0]  alloc_idx;
  logic        add_rel;
  logic        mul_rel;
  logic        cdb_valid;
  logic [2:0]  cdb_idx;
  logic [15:0] cdb_data;
  logic        commit_valid;
  logic [2:0]  commit_idx;
  logic [3:0]  commit_rd;
  logic [15:0] commit_data;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        illegal_func;

  rob_ctrl dut (
    .clk1         (clk1),
    .rst_n        (rst_n),
    .flush        (flush),
    .alloc_req    (alloc_req),
    .alloc_func   (alloc_func),
    .alloc_rd     (alloc_rd),
    .alloc_gnt    (alloc_gnt),
    .alloc_idx    (alloc_idx),
    .add_rel      (add_rel),
    .mul_rel      (mul_rel),
    .cdb_valid    (cdb_valid),
    .cdb_idx      (cdb_idx),
    .cdb_data     (cdb_data),
    .commit_valid (commit_valid),
    .commit_idx   (commit_idx),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .illegal_func (illegal_func)
  );

  typedef struct {
    int tag;
    int rd;
    bit rdy;
    int data;
  } ent_t;

  typedef struct {
    int tag;
    int rd;
    int data;
  } cm_t;

  ent_t mq[$];
  cm_t  expq[$];
  int   m_tail;
  int   m_add;
  int   m_mul;
  int   checks;
  int   errors;

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic chk(input string n, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    m_add  = 0;
    m_mul  = 0;
  endtask

  always @(negedge clk1) begin
    if (rst_n && commit_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_commit", 1, 0);
      end else begin
        cm_t e;
        e = expq.pop_front();
        chk("commit_idx", int'(commit_idx), e.tag);
        chk("commit_rd", int'(commit_rd), e.rd);
        chk("commit_data", int'(commit_data), e.data);
      end
    end
  end

  task automatic step(input bit rq, input int fn, input int rd,
                      input bit ar, input bit mr, input bit cv,
                      input int ci, input int cd, input bit fl);
    bit is_add;
    bit is_mul;
    bit ok;
    bit e_gnt;
    bit do_c;
    @(negedge clk1);
    alloc_req  = rq;
    alloc_func = 4'(fn);
    alloc_rd   = 4'(rd);
    add_rel    = ar;
    mul_rel    = mr;
    cdb_valid  = cv;
    cdb_idx    = 3'(ci);
    cdb_data   = 16'(cd);
    flush      = fl;
    #1;
    is_add = (fn == 0) || (fn == 1);
    is_mul = (fn == 2) || (fn == 3);
    ok = (is_add && m_add < RS) || (is_mul && m_mul < RS);
    e_gnt = rq && !fl && (mq.size() < 8) && ok;
    chk("count", int'(count), mq.size());
    chk("full", int'(full), int'(mq.size() == 8));
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("gnt", int'(alloc_gnt), int'(e_gnt));
    chk("illegal", int'(illegal_func),
        int'(rq && !is_add && !is_mul));
    if (e_gnt) chk("alloc_idx", int'(alloc_idx), m_tail);
    if (fl) begin
      model_reset();
    end else begin
      do_c = (mq.size() > 0) && mq[0].rdy;
      if (cv) begin
        foreach (mq[i]) begin
          if (mq[i].tag == ci && !mq[i].rdy) begin
            mq[i].rdy  = 1'b1;
            mq[i].data = cd;
          end
        end
      end
      if (do_c) begin
        expq.push_back('{mq[0].tag, mq[0].rd, mq[0].data});
        void'(mq.pop_front());
      end
      if (e_gnt && is_add && !ar) m_add++;
      else if (!(e_gnt && is_add) && ar && m_add > 0) m_add--;
      if (e_gnt && is_mul && !mr) m_mul++;
      else if (!(e_gnt && is_mul) && mr && m_mul > 0) m_mul--;
      if (e_gnt) begin
        mq.push_back('{m_tail, rd, 1'b0, 0});
        m_tail = (m_tail + 1) % 8;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input int fn, input int rd);
    step(1, fn, rd, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cdb(input int ci, input int cd);
    step(0, 0, 0, 0, 0, 1, ci, cd, 0);
  endtask

  task automatic do_flush();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic async_reset();
    @(negedge clk1);
    alloc_req = 0; add_rel = 0; mul_rel = 0;
    cdb_valid = 0; flush = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_commit_valid", int'(commit_valid), 0);
    chk("rst_commit_data", int'(commit_data), 0);
    model_reset();
    expq.delete();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int ci;
    checks = 0; errors = 0;
    model_reset();
    rst_n = 0; flush = 0; alloc_req = 0; alloc_func = 0;
    alloc_rd = 0; add_rel = 0; mul_rel = 0;
    cdb_valid = 0; cdb_idx = 0; cdb_data = 0;
    #11;
    chk("init_count", int'(count), 0);
    chk("init_empty", int'(empty), 1);
    chk("init_full", int'(full), 0);
    chk("init_commit_valid", int'(commit_valid), 0);
    #1 rst_n = 1;

    // reset mid-stream
    alloc(0, 1); alloc(1, 2); alloc(2, 3);
    async_reset();
    alloc(0, 4);
    do_flush();

    // RS credit stall
    alloc(0, 5); alloc(0, 6); alloc(0, 7);
    alloc(2, 8);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    alloc(0, 9);
    do_flush();

    // in-order retire
    alloc(0, 1); alloc(1, 2); alloc(3, 3);
    cdb(2, 16'h0003); cdb(0, 16'h0001); cdb(1, 16'h0002);
    idle(5);

    // full and wrap
    do_flush();
    for (int i = 0; i < 8; i++)
      step(1, 0, i, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0, 16'h00a0, 0);
    step(1, 0, 10, 1, 0, 0, 0, 0, 0);
    step(1, 0, 11, 1, 0, 0, 0, 0, 0);
    idle(1);
    for (int i = 1; i < 9; i++) cdb(i % 8, 16'h0100 + i);
    idle(4);

    // stale and duplicate CDB
    cdb(5, 16'hdead);
    t = m_tail;
    alloc(1, 12);
    cdb(t, 16'h1111);
    cdb(t, 16'h2222);
    idle(4);

    // flush with concurrent alloc and CDB
    do_flush();
    alloc(0, 1); alloc(2, 2); alloc(1, 3); alloc(3, 4);
    cdb(1, 16'h0011); cdb(2, 16'h0022);
    step(1, 0, 5, 0, 0, 1, 3, 16'h0033, 1);
    idle(2);
    alloc(2, 6);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) async_reset();
      ci = int'($urandom_range(0, 7));
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
        ci = mq[$urandom_range(0, mq.size() - 1)].tag;
      step($urandom_range(0, 9) < 7,
           int'($urandom_range(0, 5)),
           int'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 1) == 1,
           ci,
           int'($urandom_range(0, 65535)),
           $urandom_range(0, 99) < 2);
    end

    do_flush();
    idle(3);
    chk("scoreboard_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
